// File: rtl/hk_spi_responder_if.sv
// Register-bank bus between the SPI responder and the housekeeping registers.
//   reg_addr  : byte address for the current strobe
//   reg_wdata : write data, valid with reg_we
//   reg_we    : one-clock write strobe
//   reg_re    : one-clock read strobe
//   reg_rdata : read data, valid exactly one clock after reg_re
// master = responder side, slave = register-bank side.
interface hk_spi_responder_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/hk_spi_responder.sv
// SPI mode-0 responder for the housekeeping register bank. SCK/CSB/SDI are
// oversampled in the core clock domain; a command byte and an address byte
// are decoded, then data bytes stream with auto-incrementing address.
//   clock, resetb : core clock, async active-low reset
//   sck, csb, sdi : SPI inputs (asynchronous to clock)
//   sdo, sdo_enb  : SPI data out and its active-low enable
//   busy          : synchronized CSB, inverted
//   bus           : register-bank byte interface (master side)
module hk_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               sck,
    input  logic               csb,
    input  logic               sdi,
    output logic               sdo,
    output logic               sdo_enb,
    output logic               busy,
    hk_spi_responder_if.master bus
);
    localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [SYNC_W-1:0] sck_sync, csb_sync, sdi_sync;
    logic              sck_prev, csb_prev;
    logic              sck_rise_c, sck_fall_c, csb_rise_c, csb_fall_c, sdi_s;

    logic [2:0] state, state_d;
    logic [2:0] bit_cnt, byte_cnt, cmd_n;
    logic       cmd_wr, cmd_rd;
    logic [6:0] rx;
    logic [7:0] tx, addr;
    logic       re_pend, cap_pend;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, reg_re;
    logic       byte_done_c, last_c, active_c;
    logic [7:0] rx_byte_c;

    assign bus.reg_addr  = reg_addr;
    assign bus.reg_wdata = reg_wdata;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;

    // Input synchronizers plus one extra flop per edge-detected line.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
            csb_prev <= 1'b1;
            busy     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_W-2:0], sck};
            csb_sync <= {csb_sync[SYNC_W-2:0], csb};
            sdi_sync <= {sdi_sync[SYNC_W-2:0], sdi};
            sck_prev <= sck_sync[SYNC_W-1];
            csb_prev <= csb_sync[SYNC_W-1];
            // Fed from the stage before last so busy tracks the last stage exactly.
            busy     <= ~csb_sync[SYNC_W-2];
        end
    end

    assign sdi_s      = sdi_sync[SYNC_W-1];
    assign sck_rise_c =  sck_sync[SYNC_W-1] & ~sck_prev;
    assign sck_fall_c = ~sck_sync[SYNC_W-1] &  sck_prev;
    assign csb_rise_c =  csb_sync[SYNC_W-1] & ~csb_prev;
    assign csb_fall_c = ~csb_sync[SYNC_W-1] &  csb_prev;

    // Next-state decode and byte-boundary detection.
    always_comb begin
        state_d     = state;
        rx_byte_c   = {rx, sdi_s};
        active_c    = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
        byte_done_c = sck_rise_c && active_c && (bit_cnt == 3'd7);
        last_c      = (cmd_n != 3'd0) && (3'(byte_cnt + 3'd1) == cmd_n);
        if (csb_rise_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (csb_fall_c)  state_d = ST_CMD;
                ST_CMD:  if (byte_done_c) state_d = (rx_byte_c[7:6] == 2'b00) ? ST_DONE : ST_ADDR;
                ST_ADDR: if (byte_done_c) state_d = ST_DATA;
                ST_DATA: if (byte_done_c && last_c) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= ST_IDLE;
        else         state <= state_d;
    end

    // Shifters, counters, register-bus strobes and SDO.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bit_cnt   <= 3'd0;
            byte_cnt  <= 3'd0;
            cmd_n     <= 3'd0;
            cmd_wr    <= 1'b0;
            cmd_rd    <= 1'b0;
            rx        <= 7'd0;
            tx        <= 8'd0;
            addr      <= 8'd0;
            re_pend   <= 1'b0;
            cap_pend  <= 1'b0;
            reg_addr  <= 8'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            sdo       <= 1'b0;
            sdo_enb   <= 1'b1;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            re_pend  <= 1'b0;
            cap_pend <= reg_re;
            // Reads are issued one clock after the byte boundary so they never
            // coincide with the write strobe of the same boundary.
            if (re_pend && !csb_rise_c) begin
                reg_re   <= 1'b1;
                reg_addr <= addr;
            end
            if (csb_rise_c) begin
                sdo     <= 1'b0;
                sdo_enb <= 1'b1;
                bit_cnt <= 3'd0;
            end else begin
                if ((state == ST_IDLE) && csb_fall_c) begin
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 3'd0;
                end
                if (sck_rise_c && active_c) begin
                    rx      <= rx_byte_c[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done_c) begin
                    case (state)
                        ST_CMD: begin
                            cmd_wr <= rx_byte_c[7];
                            cmd_rd <= rx_byte_c[6];
                            cmd_n  <= rx_byte_c[5:3];
                        end
                        ST_ADDR: begin
                            addr    <= rx_byte_c;
                            re_pend <= cmd_rd;
                        end
                        ST_DATA: begin
                            if (cmd_wr) begin
                                reg_we    <= 1'b1;
                                reg_addr  <= addr;
                                reg_wdata <= rx_byte_c;
                            end
                            addr     <= addr + 8'd1;
                            byte_cnt <= byte_cnt + 3'd1;
                            // No prefetch once the last counted byte has closed.
                            re_pend  <= cmd_rd & ~last_c;
                            if (last_c) begin
                                sdo     <= 1'b0;
                                sdo_enb <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (sck_fall_c && (state == ST_DATA) && cmd_rd) begin
                    sdo     <= tx[7];
                    tx      <= {tx[6:0], 1'b0};
                    sdo_enb <= 1'b0;
                end
                if (state == ST_DONE) sdo_enb <= 1'b1;
            end
            if (cap_pend) tx <= bus.reg_rdata;
        end
    end
endmodule

// File: tb/tb_hk_spi_responder.sv
// Bench for hk_spi_responder: an SPI initiator task, a register bank, and a
// transaction-level model that predicts strobes and SDO bytes per transfer.
module tb_hk_spi_responder;
    logic clock = 1'b0;
    logic resetb, sck, csb, sdi;
    logic sdo, sdo_enb, busy;

    hk_spi_responder_if bif();

    hk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clock   (clock),
        .resetb  (resetb),
        .sck     (sck),
        .csb     (csb),
        .sdi     (sdi),
        .sdo     (sdo),
        .sdo_enb (sdo_enb),
        .busy    (busy),
        .bus     (bif)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem [256];   // register bank contents
    logic [7:0]  mm  [256];   // model's view of the bank
    logic [7:0]  dbytes  [8];
    logic [7:0]  got_sdo [8];
    logic [16:0] exp_q [$];   // {we, addr, wdata}
    logic [16:0] log_q [$];
    logic [16:0] mon_ent;
    logic        prev_we = 1'b0, prev_re = 1'b0;
    int          checks = 0, passed = 0;

    // Register bank: read data appears one clock after reg_re.
    always @(posedge clock) begin
        if (bif.reg_we) mem[bif.reg_addr] <= bif.reg_wdata;
        if (bif.reg_re) bif.reg_rdata <= mem[bif.reg_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Strobe compare process: each strobe must be the next one the model predicts.
    always @(negedge clock) begin
        if (resetb && (bif.reg_we || bif.reg_re)) begin
            mon_ent = {bif.reg_we, bif.reg_addr, bif.reg_we ? bif.reg_wdata : 8'h00};
            log_q.push_back(mon_ent);
            chk("strobe_shape", 32'((bif.reg_we & bif.reg_re) | (bif.reg_we & prev_we) |
                                    (bif.reg_re & prev_re)), 32'd0);
            checks++;
            if (exp_q.size() != 0 && exp_q[0] == mon_ent) begin
                passed++;
                void'(exp_q.pop_front());
            end else begin
                $display("FAIL strobe: got %h expected %h (queue %0d)", mon_ent,
                         (exp_q.size() != 0) ? exp_q[0] : 17'h0, exp_q.size());
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        prev_we = bif.reg_we;
        prev_re = bif.reg_re;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sdo"},       32'(sdo),           32'd0);
        chk({tag, "_sdo_enb"},   32'(sdo_enb),       32'd1);
        chk({tag, "_reg_addr"},  32'(bif.reg_addr),  32'd0);
        chk({tag, "_reg_wdata"}, 32'(bif.reg_wdata), 32'd0);
        chk({tag, "_reg_we"},    32'(bif.reg_we),    32'd0);
        chk({tag, "_reg_re"},    32'(bif.reg_re),    32'd0);
        chk({tag, "_busy"},      32'(busy),          32'd0);
    endtask

    // One SPI transfer: cmd, addr, nd full data bytes, xbits bits of one more.
    task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr, input int nd,
                        input int xbits, input int h, input bit do_reset);
        logic [7:0] exp_sdo [8];
        bit         drv [8];
        logic       w, r, bitv;
        logic [7:0] a;
        int         n, nb, total, k, j;
        w = cmd[7];
        r = cmd[6];
        n = int'(cmd[5:3]);
        a = addr;
        nb = nd + ((xbits > 0) ? 1 : 0);
        total = 16 + 8 * nd + xbits;
        log_q.delete();
        for (int i = 0; i < 8; i++) begin
            drv[i] = 1'b0;
            exp_sdo[i] = 8'h00;
            got_sdo[i] = 8'h00;
        end
        // Model: prefetch read of A, then per closed byte write/increment/prefetch.
        if (w || r) begin
            if (r) exp_q.push_back({1'b0, a, 8'h00});
            for (int i = 0; i < nb; i++) begin
                if (n != 0 && i >= n) break;
                if (r) begin
                    drv[i] = 1'b1;
                    exp_sdo[i] = mm[a];
                end
                if (i < nd) begin
                    if (w) begin
                        exp_q.push_back({1'b1, a, dbytes[i]});
                        mm[a] = dbytes[i];
                    end
                    a = a + 8'd1;
                    if (r && !(n != 0 && i == n - 1)) exp_q.push_back({1'b0, a, 8'h00});
                end
            end
        end
        @(negedge clock);
        csb = 1'b0;
        for (int b = 0; b < total; b++) begin
            k = (b >= 16) ? (b - 16) / 8 : 0;
            j = (b >= 16) ? (b - 16) % 8 : 0;
            if (b < 8)       bitv = cmd[7 - b];
            else if (b < 16) bitv = addr[15 - b];
            else             bitv = dbytes[k][7 - j];
            sdi = bitv;
            repeat (h) @(negedge clock);
            if (b >= 16 && drv[k]) begin
                chk("sdo_enb_drive", 32'(sdo_enb), 32'd0);
                chk("sdo_bit", 32'(sdo), 32'(exp_sdo[k][7 - j]));
                got_sdo[k][7 - j] = sdo;
            end else begin
                chk("sdo_enb_quiet", 32'(sdo_enb), 32'd1);
            end
            if (b == 0) chk("busy_active", 32'(busy), 32'd1);
            sck = 1'b1;
            repeat (h) @(negedge clock);
            sck = 1'b0;
        end
        repeat (h) @(negedge clock);
        if (do_reset) begin
            chk("pre_reset_enb", 32'(sdo_enb), 32'd0);
            chk("pre_reset_addr", 32'(bif.reg_addr), 32'(addr));
            #2;
            resetb = 1'b0;
            csb = 1'b1;
            sck = 1'b0;
            #1;
            chk_reset_vals("async_reset");
            repeat (3) @(negedge clock);
            resetb = 1'b1;
            exp_q.delete();
            repeat (4) @(negedge clock);
        end else begin
            csb = 1'b1;
            repeat (8) @(negedge clock);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("sdo_enb_after", 32'(sdo_enb), 32'd1);
            chk("strobes_missing", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic chk_log(input string name, input int i, input logic [16:0] e);
        if (i < log_q.size()) chk(name, 32'(log_q[i]), 32'(e));
        else chk({name, "_len"}, 32'(log_q.size()), 32'(i + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        resetb = 1'b0;
        sck = 1'b0;
        csb = 1'b1;
        sdi = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            mm[i]  = mem[i];
        end
        mem[1] = 8'h04; mem[2] = 8'h56; mem[3] = 8'h10; mem[5] = 8'hEF;
        mm[1]  = 8'h04; mm[2]  = 8'h56; mm[3]  = 8'h10; mm[5]  = 8'hEF;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        resetb = 1'b1;
        repeat (4) @(negedge clock);

        // Streaming read at minimum half-period.
        xfer(8'h40, 8'h01, 3, 0, 4, 1'b0);
        chk("rd_byte0", 32'(got_sdo[0]), 32'h04);
        chk("rd_byte1", 32'(got_sdo[1]), 32'h56);
        chk("rd_byte2", 32'(got_sdo[2]), 32'h10);
        chk("rd_log_len", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("rd_log", i, {1'b0, 8'(i + 1), 8'h00});

        // Two-byte write at a slow SCK; third byte ignored.
        dbytes[0] = 8'h12; dbytes[1] = 8'h34; dbytes[2] = 8'hFF;
        xfer(8'h90, 8'h08, 3, 0, 37, 1'b0);
        chk("wr_log_len", 32'(log_q.size()), 32'd2);
        chk_log("wr_log0", 0, {1'b1, 8'h08, 8'h12});
        chk_log("wr_log1", 1, {1'b1, 8'h09, 8'h34});

        // Address wrap.
        dbytes[0] = 8'hAA; dbytes[1] = 8'hBB;
        xfer(8'h80, 8'hFF, 2, 0, 6, 1'b0);
        chk_log("wrap_log0", 0, {1'b1, 8'hFF, 8'hAA});
        chk_log("wrap_log1", 1, {1'b1, 8'h00, 8'hBB});

        // Read/write single byte.
        dbytes[0] = 8'h03;
        xfer(8'hC8, 8'h05, 1, 0, 5, 1'b0);
        chk("rw_sdo", 32'(got_sdo[0]), 32'hEF);
        chk("rw_log_len", 32'(log_q.size()), 32'd2);
        chk_log("rw_log0", 0, {1'b0, 8'h05, 8'h00});
        chk_log("rw_log1", 1, {1'b1, 8'h05, 8'h03});

        // Abort after 5 data bits of a write, then a read.
        dbytes[0] = 8'h5A;
        xfer(8'h80, 8'h20, 0, 5, 5, 1'b0);
        chk("abort_log_len", 32'(log_q.size()), 32'd0);
        xfer(8'h40, 8'h02, 1, 0, 4, 1'b0);
        chk("abort_rd", 32'(got_sdo[0]), 32'h56);

        // Reset mid-byte during a read, then a clean read.
        xfer(8'h40, 8'h10, 0, 3, 5, 1'b1);
        xfer(8'h40, 8'h01, 1, 0, 4, 1'b0);
        chk("post_reset_rd", 32'(got_sdo[0]), 32'h04);

        // Randomized transfers.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) dbytes[i] = 8'($urandom);
            xfer(8'($urandom), 8'($urandom), $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                 $urandom_range(4, 9), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/hk_spi_responder.md
Name: hk_spi_responder

Overview:
- SPI mode-0 responder (slave) for the housekeeping register bank. It is the far end of the transactions that management firmware issues through the SoC SPI master to read chip IDs and configuration bytes.
- SCK, CSB and SDI are oversampled in the core clock domain; there is no second clock.
- It decodes a command byte and an address byte, then streams data bytes with auto-incrementing address.
- Register access goes over a simple single-port byte interface to the register bank.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on SCK, CSB and SDI (minimum 2).

Ports:
- clock  input  1  core clock; all logic is on the rising edge.
- resetb  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock from the initiator; asynchronous to clock.
- csb  input  1  SPI chip select, active low.
- sdi  input  1  SPI serial data in, MSB first.
- sdo  output  1  SPI serial data out, MSB first.
- sdo_enb  output  1  SDO output enable, active low.
- reg_addr  output  8  register address.
- reg_wdata  output  8  write data.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; valid exactly one clock after reg_re.
- busy  output  1  high while CSB is low (synchronized).

Behaviour:
- Reset values: sdo=0, sdo_enb=1, reg_addr=0x00, reg_wdata=0x00, reg_we=0, reg_re=0, busy=0. State is IDLE and the bit counter is 0.
- Synchronizers and edge detection:
  - sck, csb and sdi each pass through SYNC_STAGES flops.
  - A rise or fall event is one clock wide, taken from the last synchronized stage versus its previous value.
- Timing constraint: the SCK high time and low time must each be at least 4 clock periods. Slower SCK must work at any ratio.
- SDI is sampled on each SCK rise event. SDO is updated on each SCK fall event. A bit counter (0..7) increments on each rise event.
- State machine:
  - IDLE: enter on a CSB fall event, clearing the bit counter, and go to COMMAND.
  - COMMAND: after 8 bits, latch cmd[7:0] and go to ADDRESS.
    - cmd[7] = write, cmd[6] = read, cmd[5:3] = byte count n (0 = streaming).
    - cmd[7:6] = 00 is a no-op: go to DONE.
  - ADDRESS: after 8 bits, load the address register and go to DATA.
    - If read is set, pulse reg_re with reg_addr = address on the next clock.
    - Capture reg_rdata one clock later into the transmit shifter.
    - Drive sdo_enb=0 and put the MSB on sdo at the next SCK fall event.
  - DATA: each complete 8th rise event closes one byte.
    - If write: pulse reg_we for one clock with reg_addr = current address and reg_wdata = received byte.
    - Increment the address (8-bit, 0xFF wraps to 0x00).
    - If read: pulse reg_re at the new address on the clock after any reg_we, never in the same clock. Capture reg_rdata one clock later.
    - The next fall event shifts out the new byte's MSB. Within a byte, each fall event shifts the next bit.
    - When n≠0 and n bytes have completed, go to DONE.
  - DONE: ignore SCK, hold sdo_enb=1, wait for CSB to rise.
- A CSB rise event in any state returns to IDLE:
  - sdo_enb=1, sdo=0, and the bit counter clears.
  - A partial byte is discarded with no reg_we.
  - A strobe already issued in that clock still completes.
- Read/write mode (cmd[7:6]=11): the received byte is written to address A, and the byte shifted out for that slot is the value read from A before the write.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronously).
- reg_we and reg_re are never high in the same clock, and each is exactly one clock wide.
- busy follows the synchronized CSB, inverted.

Test Plan:
- Read streaming: cmd 0x40, addr 0x01, 3 bytes clocked; the bank holds 0x01=0x04, 0x02=0x56, 0x03=0x10.
  - Required: SDO bytes 0x04, 0x56, 0x10.
  - Required: reg_re pulses at 0x01, 0x02, 0x03, 0x04 (prefetch).
  - Required: no reg_we.
- Write n-byte: cmd 0x90 (n=2), addr 0x08, data 0x12, 0x34, then a third byte 0xFF.
  - Required: reg_we at 0x08=0x12 and 0x09=0x34 only.
  - Required: the third byte is ignored and sdo_enb stays 1 throughout.
- Address wrap: cmd 0x80, addr 0xFF, data 0xAA, 0xBB.
  - Required: writes 0xFF=0xAA, then 0x00=0xBB.
- Read/write: cmd 0xC8 (n=1), addr 0x05, bank 0x05=0xEF, SDI byte 0x03.
  - Required: SDO shifts 0xEF.
  - Required: reg_we 0x05=0x03, followed by no further strobes.
- Abort: CSB rises after 5 data bits of a write → no reg_we; state IDLE; sdo_enb=1. A following cmd 0x40 addr 0x02 read returns 0x56.
- SCK at minimum half-period (4 clocks) and at 37 clocks; assert resetb low mid-byte → all outputs at reset values within the same clock; a subsequent transaction is correct.
